// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port, single-port RAM
// port and the busy flag. The slave modport is the arbiter's view and the
// master modport is the view of the requesters plus the RAM.
interface mem_arbiter_if #(
    parameter int ADDR_W = 11
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    // load/store port
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [31:0]       ls_rdata;

    // RAM port
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_w_en;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        output ram_addr, ram_w_en, ram_wdata, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        input  ram_addr, ram_w_en, ram_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read RAM.
// Load/store normally wins over fetch; a starvation counter forces a fetch
// grant once fetch has been denied MAX_WAIT consecutive cycles.
// Reads take two cycles (grant, then data), stores complete in the grant
// cycle and leave the arbiter in IDLE so stores can issue every cycle.
module mem_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_DATA = 2'd1,
        LS_DATA = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        starve_reg, starve_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;

    logic              if_gnt_c;
    logic              ls_gnt_c;
    logic              if_rvalid_c;
    logic              ls_rvalid_c;
    logic [31:0]       if_rdata_c;
    logic [31:0]       ls_rdata_c;
    logic              ram_w_en_c;
    logic [31:0]       ram_wdata_c;

    // State, starvation counter and last granted address; cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            starve_reg <= 4'd0;
            addr_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
            addr_reg   <= addr_next;
        end
    end

    // Arbitration, next state and all response/RAM outputs.
    // Grants are qualified with rst_n so every output is 0 while reset is held,
    // even if a requester keeps its request asserted.
    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        if_gnt_c    = 1'b0;
        ls_gnt_c    = 1'b0;
        if_rvalid_c = 1'b0;
        ls_rvalid_c = 1'b0;
        if_rdata_c  = 32'd0;
        ls_rdata_c  = 32'd0;
        ram_w_en_c  = 1'b0;
        ram_wdata_c = 32'd0;
        case (state_reg)
            IDLE: begin
                if (rst_n) begin
                    if (bus.if_req && (!bus.ls_req || starve_reg == MAX_WAIT_C)) begin
                        if_gnt_c   = 1'b1;
                        addr_next  = bus.if_addr;
                        state_next = IF_DATA;
                    end else if (bus.ls_req) begin
                        ls_gnt_c  = 1'b1;
                        addr_next = bus.ls_addr;
                        if (bus.ls_we) begin
                            ram_w_en_c  = 1'b1;
                            ram_wdata_c = bus.ls_wdata;
                        end else begin
                            state_next = LS_DATA;
                        end
                    end
                end
            end
            IF_DATA: begin
                if_rvalid_c = 1'b1;
                if_rdata_c  = bus.ram_rdata;
                state_next  = IDLE;
            end
            LS_DATA: begin
                ls_rvalid_c = 1'b1;
                ls_rdata_c  = bus.ram_rdata;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Starvation counter: counts consecutive cycles fetch waits, in any state.
    always_comb begin
        starve_next = 4'd0;
        if (bus.if_req && !if_gnt_c) begin
            starve_next = (starve_reg >= MAX_WAIT_C) ? MAX_WAIT_C : starve_reg + 4'd1;
        end
    end

    // The RAM address follows a grant combinationally and otherwise holds.
    assign bus.ram_addr  = addr_next;
    assign bus.ram_w_en  = ram_w_en_c;
    assign bus.ram_wdata = ram_wdata_c;
    assign bus.if_gnt    = if_gnt_c;
    assign bus.ls_gnt    = ls_gnt_c;
    assign bus.if_rvalid = if_rvalid_c;
    assign bus.ls_rvalid = ls_rvalid_c;
    assign bus.if_rdata  = if_rdata_c;
    assign bus.ls_rdata  = ls_rdata_c;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written starvation and
// reset sequences, then random traffic against a reference memory model.
module tb_mem_arbiter;
    localparam int ADDR_W   = 11;
    localparam int MAX_WAIT = 4;

    logic clk;
    logic rst_n;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM device with synchronous read and a preload port used during reset.
    logic [31:0]       ram [0:255];
    logic              init_we;
    logic [7:0]        init_addr;
    logic [31:0]       init_data;
    always @(posedge clk) begin
        if (init_we) ram[init_addr] <= init_data;
        else if (bus.ram_w_en) ram[bus.ram_addr[7:0]] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr[7:0]];
    end

    // reference memory contents as seen by the requesters
    logic [31:0] ref_mem [0:255];

    int n_vec;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // expected-flag bit positions
    localparam logic [5:0] F_IG = 6'b100000;
    localparam logic [5:0] F_LG = 6'b010000;
    localparam logic [5:0] F_IV = 6'b001000;
    localparam logic [5:0] F_LV = 6'b000100;
    localparam logic [5:0] F_BY = 6'b000010;
    localparam logic [5:0] F_WE = 6'b000001;

    typedef struct {
        logic        rst_n;
        logic        if_req;
        logic [10:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [10:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [5:0]  flags;
        logic [10:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_if_rdata;
        logic [31:0] e_ls_rdata;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic ir, input logic [10:0] ia,
                                input logic lr, input logic lw, input logic [10:0] la,
                                input logic [31:0] ld, input logic [5:0] f,
                                input logic [10:0] ea, input logic [31:0] ew,
                                input logic [31:0] eir, input logic [31:0] elr);
        vec_t v;
        v.rst_n = r;   v.if_req = ir; v.if_addr = ia;
        v.ls_req = lr; v.ls_we = lw;  v.ls_addr = la; v.ls_wdata = ld;
        v.flags = f;   v.e_addr = ea; v.e_wdata = ew;
        v.e_if_rdata = eir; v.e_ls_rdata = elr;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input logic [5:0] f, input logic [10:0] ea,
                                 input logic [31:0] ew, input logic [31:0] eir,
                                 input logic [31:0] elr);
        chk({tag, ".if_gnt"},    32'(bus.if_gnt),    32'(f[5]));
        chk({tag, ".ls_gnt"},    32'(bus.ls_gnt),    32'(f[4]));
        chk({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 32'(f[3]));
        chk({tag, ".ls_rvalid"}, 32'(bus.ls_rvalid), 32'(f[2]));
        chk({tag, ".busy"},      32'(bus.busy),      32'(f[1]));
        chk({tag, ".ram_w_en"},  32'(bus.ram_w_en),  32'(f[0]));
        chk({tag, ".ram_addr"},  32'(bus.ram_addr),  32'(ea));
        chk({tag, ".ram_wdata"}, bus.ram_wdata,      ew);
        chk({tag, ".if_rdata"},  bus.if_rdata,       eir);
        chk({tag, ".ls_rdata"},  bus.ls_rdata,       elr);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        @(posedge clk);
        #1;
        rst_n        = v.rst_n;
        bus.if_req   = v.if_req;
        bus.if_addr  = v.if_addr;
        bus.ls_req   = v.ls_req;
        bus.ls_we    = v.ls_we;
        bus.ls_addr  = v.ls_addr;
        bus.ls_wdata = v.ls_wdata;
        @(negedge clk);
        check_outputs($sformatf("vec%0d", idx), v.flags, v.e_addr, v.e_wdata,
                      v.e_if_rdata, v.e_ls_rdata);
        if ((v.flags & F_WE) != 0) ref_mem[v.ls_addr[7:0]] = v.ls_wdata;
        $display("vec %0d: rst_n=%0b if_req=%0b ls_req=%0b we=%0b -> gnt if/ls=%0b/%0b rvalid if/ls=%0b/%0b addr=0x%03h",
                 idx, v.rst_n, v.if_req, v.ls_req, v.ls_we, bus.if_gnt, bus.ls_gnt,
                 bus.if_rvalid, bus.ls_rvalid, bus.ram_addr);
    endtask

    vec_t vecs [13];

    // random-phase model state
    int          resp_due;      // 0 none, 1 fetch data due, 2 load data due
    logic [31:0] resp_data;
    int          wait_cnt;
    logic        if_pend, ls_pend;
    logic        last_if_gnt, last_ls_gnt;
    logic        e_if_gnt, e_ls_gnt;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        init_we = 1'b0; init_addr = '0; init_data = '0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;

        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[8'h10] = 32'hDEADBEEF;
        ref_mem[8'h55] = 32'hCAFEF00D;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            init_we = 1'b1; init_addr = 8'(i); init_data = ref_mem[i];
        end
        @(posedge clk);
        #1;
        init_we = 1'b0;

        //            rst ir  if_addr lr  we  ls_addr ls_wdata      flags              e_addr  e_wdata       e_if_rdata    e_ls_rdata
        vecs[0]  = mk(0, 1, 11'h0A0, 1, 0, 11'h010, 32'h0,        6'b0,              11'h000, 32'h0,        32'h0,        32'h0);
        vecs[1]  = mk(1, 0, 11'h000, 1, 0, 11'h010, 32'h0,        F_LG,              11'h010, 32'h0,        32'h0,        32'h0);
        vecs[2]  = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        F_LV | F_BY,       11'h010, 32'h0,        32'h0,        32'hDEADBEEF);
        vecs[3]  = mk(1, 0, 11'h000, 1, 1, 11'h020, 32'h12345678, F_LG | F_WE,       11'h020, 32'h12345678, 32'h0,        32'h0);
        vecs[4]  = mk(1, 0, 11'h000, 1, 0, 11'h020, 32'h0,        F_LG,              11'h020, 32'h0,        32'h0,        32'h0);
        vecs[5]  = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        F_LV | F_BY,       11'h020, 32'h0,        32'h0,        32'h12345678);
        vecs[6]  = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b0,              11'h020, 32'h0,        32'h0,        32'h0);
        vecs[7]  = mk(1, 1, 11'h055, 0, 0, 11'h000, 32'h0,        F_IG,              11'h055, 32'h0,        32'h0,        32'h0);
        vecs[8]  = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        F_IV | F_BY,       11'h055, 32'h0,        32'hCAFEF00D, 32'h0);
        vecs[9]  = mk(1, 1, 11'h056, 1, 1, 11'h030, 32'hA5A5A5A5, F_LG | F_WE,       11'h030, 32'hA5A5A5A5, 32'h0,        32'h0);
        vecs[10] = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        6'b0,              11'h030, 32'h0,        32'h0,        32'h0);
        vecs[11] = mk(1, 0, 11'h000, 1, 0, 11'h030, 32'h0,        F_LG,              11'h030, 32'h0,        32'h0,        32'h0);
        vecs[12] = mk(1, 0, 11'h000, 0, 0, 11'h000, 32'h0,        F_LV | F_BY,       11'h030, 32'h0,        32'h0,        32'hA5A5A5A5);
        for (int i = 0; i < 13; i++) apply_vec(i, vecs[i]);

        // Both ports held, loads: ls at 0 and 2, fetch forced at 4.
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            bus.if_req = (c < 5); bus.if_addr = 11'h0A0;
            bus.ls_req = (c < 5); bus.ls_we = 1'b0; bus.ls_addr = 11'h0B0;
            @(negedge clk);
            chk($sformatf("starve_ld%0d.ls_gnt", c), 32'(bus.ls_gnt), 32'(c == 0 || c == 2));
            chk($sformatf("starve_ld%0d.if_gnt", c), 32'(bus.if_gnt), 32'(c == 4));
            chk($sformatf("starve_ld%0d.ls_rvalid", c), 32'(bus.ls_rvalid), 32'(c == 1 || c == 3));
            chk($sformatf("starve_ld%0d.if_rvalid", c), 32'(bus.if_rvalid), 32'(c == 5));
            if (c == 1 || c == 3) chk($sformatf("starve_ld%0d.ls_rdata", c), bus.ls_rdata, ref_mem[8'hB0]);
            if (c == 5) chk("starve_ld5.if_rdata", bus.if_rdata, ref_mem[8'hA0]);
            $display("starve load cycle %0d: if_gnt=%0b ls_gnt=%0b", c, bus.if_gnt, bus.ls_gnt);
        end

        // Back-to-back stores with fetch waiting: fetch wins on the 5th cycle.
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            bus.if_req = (c < 5); bus.if_addr = 11'h0A1;
            bus.ls_req = (c < 5); bus.ls_we = 1'b1;
            bus.ls_addr = 11'(11'h0C0 + c); bus.ls_wdata = 32'h1000 + 32'(c);
            @(negedge clk);
            chk($sformatf("starve_st%0d.ls_gnt", c), 32'(bus.ls_gnt), 32'(c < 4));
            chk($sformatf("starve_st%0d.ram_w_en", c), 32'(bus.ram_w_en), 32'(c < 4));
            chk($sformatf("starve_st%0d.if_gnt", c), 32'(bus.if_gnt), 32'(c == 4));
            if (c < 4) ref_mem[8'hC0 + 8'(c)] = 32'h1000 + 32'(c);
            if (c == 5) chk("starve_st5.if_rdata", bus.if_rdata, ref_mem[8'hA1]);
            $display("starve store cycle %0d: if_gnt=%0b ls_gnt=%0b w_en=%0b", c, bus.if_gnt, bus.ls_gnt, bus.ram_w_en);
        end

        // Reset pulse while fetch data is pending drops the response.
        @(posedge clk);
        #1;
        bus.if_req = 1'b1; bus.if_addr = 11'h055; bus.ls_req = 1'b0;
        @(negedge clk);
        chk("rst_pend.if_gnt", 32'(bus.if_gnt), 32'd1);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_pend.if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("rst_pend.busy", 32'(bus.busy), 32'd0);
        chk("rst_pend.ram_addr", 32'(bus.ram_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d.if_rvalid", c), 32'(bus.if_rvalid), 32'd0);
            chk($sformatf("rst_after%0d.busy", c), 32'(bus.busy), 32'd0);
            @(posedge clk);
            #1;
        end
        $display("reset during IF_DATA: response dropped");

        // Random mixed traffic against the reference memory.
        resp_due = 0; resp_data = '0; wait_cnt = 0;
        if_pend = 1'b0; ls_pend = 1'b0; last_if_gnt = 1'b0; last_ls_gnt = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #1;
            if (last_if_gnt) if_pend = 1'b0;
            if (last_ls_gnt) ls_pend = 1'b0;
            if (!if_pend && $urandom_range(0, 2) != 0) begin
                if_pend = 1'b1;
                bus.if_addr = 11'($urandom_range(0, 255));
            end
            if (!ls_pend && $urandom_range(0, 1) == 0) begin
                ls_pend = 1'b1;
                bus.ls_we = 1'($urandom_range(0, 1));
                bus.ls_addr = 11'($urandom_range(0, 255));
                bus.ls_wdata = $urandom;
            end
            bus.if_req = if_pend;
            bus.ls_req = ls_pend;
            @(negedge clk);
            e_if_gnt = 1'b0;
            e_ls_gnt = 1'b0;
            if (resp_due == 0) begin
                if (if_pend && (!ls_pend || wait_cnt == MAX_WAIT)) e_if_gnt = 1'b1;
                else if (ls_pend) e_ls_gnt = 1'b1;
            end
            chk("rnd.if_gnt", 32'(bus.if_gnt), 32'(e_if_gnt));
            chk("rnd.ls_gnt", 32'(bus.ls_gnt), 32'(e_ls_gnt));
            chk("rnd.if_rvalid", 32'(bus.if_rvalid), 32'(resp_due == 1));
            chk("rnd.ls_rvalid", 32'(bus.ls_rvalid), 32'(resp_due == 2));
            chk("rnd.busy", 32'(bus.busy), 32'(resp_due != 0));
            chk("rnd.ram_w_en", 32'(bus.ram_w_en), 32'(e_ls_gnt && bus.ls_we));
            if (resp_due == 1) chk("rnd.if_rdata", bus.if_rdata, resp_data);
            if (resp_due == 2) chk("rnd.ls_rdata", bus.ls_rdata, resp_data);
            if (e_if_gnt) chk("rnd.ram_addr_if", 32'(bus.ram_addr), 32'(bus.if_addr));
            if (e_ls_gnt) chk("rnd.ram_addr_ls", 32'(bus.ram_addr), 32'(bus.ls_addr));
            if (e_ls_gnt && bus.ls_we) chk("rnd.ram_wdata", bus.ram_wdata, bus.ls_wdata);

            if (e_if_gnt)
                $display("txn %0d: fetch addr=0x%03h expect 0x%08h", t, bus.if_addr, ref_mem[bus.if_addr[7:0]]);
            else if (e_ls_gnt)
                $display("txn %0d: %s addr=0x%03h data=0x%08h", t, bus.ls_we ? "store" : "load",
                         bus.ls_addr, bus.ls_we ? bus.ls_wdata : ref_mem[bus.ls_addr[7:0]]);

            // advance the model by one cycle
            if (e_if_gnt) begin
                resp_due  = 1;
                resp_data = ref_mem[bus.if_addr[7:0]];
            end else if (e_ls_gnt && !bus.ls_we) begin
                resp_due  = 2;
                resp_data = ref_mem[bus.ls_addr[7:0]];
            end else begin
                resp_due = 0;
                if (e_ls_gnt) ref_mem[bus.ls_addr[7:0]] = bus.ls_wdata;
            end
            if (if_pend && !e_if_gnt) wait_cnt = (wait_cnt >= MAX_WAIT) ? MAX_WAIT : wait_cnt + 1;
            else wait_cnt = 0;
            last_if_gnt = bus.if_gnt;
            last_ls_gnt = bus.ls_gnt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
Parameters:
REQ-001 ADDR_W, 11, RAM word-address width.
REQ-002 MAX_WAIT, 4, consecutive denied fetch cycles before fetch gets forced priority; legal range 1..15.

Ports:
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  fetch read request; held with if_addr until if_gnt.
REQ-006 if_addr  in  ADDR_W  fetch word address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle (combinational).
REQ-008 if_rvalid  out  1  if_rdata valid (registered state decode).
REQ-009 if_rdata  out  32  fetch read data.
REQ-010 ls_req  in  1  load/store request; held with ls_we/ls_addr/ls_wdata until ls_gnt.
REQ-011 ls_we  in  1  1 = store, 0 = load.
REQ-012 ls_addr  in  ADDR_W  load/store word address.
REQ-013 ls_wdata  in  32  store data.
REQ-014 ls_gnt  out  1  load/store request accepted this cycle (combinational).
REQ-015 ls_rvalid  out  1  ls_rdata valid (loads only).
REQ-016 ls_rdata  out  32  load read data.
REQ-017 ram_addr  out  ADDR_W  single-port RAM address.
REQ-018 ram_w_en  out  1  RAM write enable.
REQ-019 ram_wdata  out  32  RAM write data.
REQ-020 ram_rdata  in  32  RAM read data; valid one cycle after address (synchronous read).
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 FSM states SHALL be IDLE, IF_DATA, LS_DATA; requests are accepted only in IDLE.
REQ-023 In IDLE with only ls_req: ls_gnt=1, ram_addr=ls_addr; load -> LS_DATA; store -> ram_w_en=1, ram_wdata=ls_wdata, remain IDLE.
REQ-024 In IDLE with only if_req: if_gnt=1, ram_addr=if_addr, ram_w_en=0, next state IF_DATA.
REQ-025 In IDLE with both requests: ls wins unless starve counter == MAX_WAIT, in which case fetch wins.
REQ-026 Starve counter (4 bits): clear when if_gnt=1 or if_req=0; else increment (saturating at MAX_WAIT) each cycle if_req=1 and if_gnt=0, including cycles outside IDLE.
REQ-027 IF_DATA: if_rvalid=1, if_rdata=ram_rdata, no grants, next state IDLE.
REQ-028 LS_DATA: ls_rvalid=1, ls_rdata=ram_rdata, no grants, next state IDLE.
REQ-029 Read latency SHALL be exactly 1 cycle from gnt to rvalid; read throughput one per 2 cycles; stores one per cycle.
REQ-030 if_gnt and ls_gnt SHALL never both be 1; at most one rvalid high per cycle; ram_w_en=1 only with ls_gnt=1 and ls_we=1.
REQ-031 Outside IDLE, ram_addr SHALL hold the last granted address and ram_w_en=0.
REQ-032 When not driven by a grant, rdata outputs SHALL read 0 and ram_wdata SHALL be 0.
REQ-033 No requests in IDLE: all gnt/rvalid/ram_w_en 0, state unchanged.

Reset
REQ-034 rst_n low SHALL force IDLE, starve counter 0, and all outputs 0 (including ram_addr, rvalids, gnts, busy) asynchronously.
REQ-035 Reset during IF_DATA/LS_DATA SHALL drop the pending response; no rvalid is issued after release.
REQ-036 First grant possible on the first rising edge after rst_n deasserts.

Verification
REQ-037 ls_req=1, ls_we=0, ls_addr=0x010, RAM[0x010]=0xDEADBEEF -> ls_gnt cycle N, ls_rvalid=1 with ls_rdata=0xDEADBEEF cycle N+1, busy=1 at N+1.
REQ-038 Store ls_addr=0x020, ls_wdata=0x12345678 -> ram_w_en=1, ram_addr=0x020 same cycle, state stays IDLE, following load of 0x020 returns 0x12345678.
REQ-039 if_req and ls_req both held high (ls loads), MAX_WAIT=4 -> ls granted at cycles 0, 2 (fetch denied 4 cycles: 0-3), fetch granted at cycle 4, counter cleared.
REQ-040 Back-to-back stores with if_req high, MAX_WAIT=4 -> fetch granted on the 5th cycle; no store issued that cycle.
REQ-041 rst_n pulsed low during IF_DATA -> if_rvalid=0 immediately, busy=0, no response after release.
REQ-042 Randomised mixed traffic vs. reference memory model -> all read data matches, gnts mutually exclusive, every gnt'd read yields exactly one rvalid.
